pxs_pattern_gen: RTL and testbench

PXS_PATTERN_GEN -- requirements
Module: pxs_pattern_gen

---
 rtl/pxs_pkg.sv | 23 ++
 rtl/pxs_pattern_gen_if.sv | 15 +
 rtl/pxs_frame_ctl.sv | 65 ++++++
 rtl/pxs_pattern_gen.sv | 72 +++++++
 tb/tb_pxs_pattern_gen.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/pxs_pkg.sv
// Shared pixel-stream definitions: stream field positions and pattern mode encodings.
package pxs_pkg;

    localparam int unsigned STR_W   = 23;
    localparam int unsigned XC_W    = 10;
    localparam int unsigned YC_W    = 10;
    localparam int unsigned MODE_W  = 2;

    localparam int unsigned ACT_BIT = 0;
    localparam int unsigned YC_LSB  = 1;
    localparam int unsigned XC_LSB  = 11;
    localparam int unsigned VS_BIT  = 21;
    localparam int unsigned HS_BIT  = 22;
    localparam int unsigned RGB_LSB = 23;

    typedef enum logic [MODE_W-1:0] {
        MODE_VBAR  = 2'd0,
        MODE_HBAR  = 2'd1,
        MODE_CHECK = 2'd2,
        MODE_RAMP  = 2'd3
    } mode_e;

endpackage

// File: rtl/pxs_pattern_gen_if.sv
// Stream-side bundle for the pattern generator: mode select, input timing stream, coloured output stream.
interface pxs_pattern_gen_if
    import pxs_pkg::*;
#(
    parameter int unsigned CW = 1
);
    localparam int unsigned OUT_W = STR_W + 3 * CW;

    logic [MODE_W-1:0] mode;
    logic [STR_W-1:0]  vga_str;
    logic [OUT_W-1:0]  rgb_str;

    modport master (output mode, output vga_str, input rgb_str);
    modport slave  (input mode, input vga_str, output rgb_str);
endinterface

// File: rtl/pxs_frame_ctl.sv
// Frame control: VS edge detect, per-frame mode latch and (with PXS_PATTERN_SCROLL_EN) the scroll offset.
// The _c outputs are the values in force for the current pixel, so a frame-start pixel already sees the new frame.
module pxs_frame_ctl
    import pxs_pkg::*;
#(
    parameter logic        VS_ACTIVE   = 1'b0,
    parameter int unsigned SCROLL_STEP = 1
)(
    input  logic              px_clk,
    input  logic              rst_n,
    input  logic              vs_i,
    input  logic [MODE_W-1:0] mode_i,
    output mode_e             mode_c,
    output logic [XC_W-1:0]   offset_c
);

    logic  vs_prev_q, vs_prev_d;
    logic  armed_q, armed_d;
    logic  frame_start_c;
    mode_e mode_q, mode_d;
`ifdef PXS_PATTERN_SCROLL_EN
    logic [XC_W-1:0] offset_q, offset_d;
`endif

    // Edge detect is suppressed on the first cycle out of reset so a VS already asserted is not a frame start
    always_comb begin
        vs_prev_d     = vs_i;
        armed_d       = 1'b1;
        frame_start_c = armed_q && (vs_i == VS_ACTIVE) && (vs_prev_q != VS_ACTIVE);
        mode_d        = mode_q;
        if (frame_start_c) begin
            mode_d = mode_e'(mode_i);
        end
        mode_c = mode_d;
`ifdef PXS_PATTERN_SCROLL_EN
        offset_d = offset_q;
        if (frame_start_c) begin
            offset_d = offset_q + XC_W'(SCROLL_STEP);
        end
        offset_c = offset_d;
`else
        offset_c = '0;
`endif
    end

    // Frame control state
    always_ff @(posedge px_clk or negedge rst_n) begin
        if (!rst_n) begin
            vs_prev_q <= ~VS_ACTIVE;
            armed_q   <= 1'b0;
            mode_q    <= MODE_VBAR;
`ifdef PXS_PATTERN_SCROLL_EN
            offset_q  <= '0;
`endif
        end else begin
            vs_prev_q <= vs_prev_d;
            armed_q   <= armed_d;
            mode_q    <= mode_d;
`ifdef PXS_PATTERN_SCROLL_EN
            offset_q  <= offset_d;
`endif
        end
    end

endmodule

// File: rtl/pxs_pattern_gen.sv
// Test pattern generator: colours a VGA timing stream with bars, checkerboard or grey ramp, one-cycle latency.
// Optional feature macro: PXS_PATTERN_SCROLL_EN (per-frame horizontal scroll of the pattern).
module pxs_pattern_gen
    import pxs_pkg::*;
#(
    parameter int unsigned CW          = 1,
    parameter int unsigned BAR_LOG2    = 3,
    parameter logic        VS_ACTIVE   = 1'b0,
    parameter int unsigned SCROLL_STEP = 1
)(
    input  logic                    px_clk,
    input  logic                    rst_n,
    input  logic [MODE_W-1:0]       mode_i,
    input  logic [STR_W-1:0]        VGAStr_i,
    output logic [STR_W+3*CW-1:0]   RGBStr_o
);

    localparam int unsigned OUT_W = STR_W + 3 * CW;

    mode_e            mode_c;
    logic [XC_W-1:0]  offset_c;
    logic [XC_W-1:0]  xc, sx;
    logic [YC_W-1:0]  sy;
    logic [2:0]       bar_x, bar_y;
    logic [3*CW-1:0]  rgb_c;
    logic [OUT_W-1:0] rgb_str_q, rgb_str_d;

    pxs_frame_ctl #(
        .VS_ACTIVE   (VS_ACTIVE),
        .SCROLL_STEP (SCROLL_STEP)
    ) u_frame_ctl (
        .px_clk   (px_clk),
        .rst_n    (rst_n),
        .vs_i     (VGAStr_i[VS_BIT]),
        .mode_i   (mode_i),
        .mode_c   (mode_c),
        .offset_c (offset_c)
    );

    // Pixel colouring from scrolled coordinates; blanked outside the active area
    always_comb begin
        xc    = VGAStr_i[XC_LSB +: XC_W];
        sy    = VGAStr_i[YC_LSB +: YC_W];
        sx    = xc + offset_c;
        bar_x = 3'(sx >> BAR_LOG2);
        bar_y = 3'(sy >> BAR_LOG2);
        rgb_c = '0;
        unique case (mode_c)
            MODE_VBAR:  rgb_c = {{CW{bar_x[2]}}, {CW{bar_x[1]}}, {CW{bar_x[0]}}};
            MODE_HBAR:  rgb_c = {{CW{bar_y[2]}}, {CW{bar_y[1]}}, {CW{bar_y[0]}}};
            MODE_CHECK: rgb_c = {(3 * CW){bar_x[0] ^ bar_y[0]}};
            MODE_RAMP:  rgb_c = {3{sx[XC_W-1 -: CW]}};
            default:    rgb_c = '0;
        endcase
        if (!VGAStr_i[ACT_BIT]) begin
            rgb_c = '0;
        end
        rgb_str_d = {rgb_c, VGAStr_i};
    end

    // Output stream register
    always_ff @(posedge px_clk or negedge rst_n) begin
        if (!rst_n) begin
            rgb_str_q <= '0;
        end else begin
            rgb_str_q <= rgb_str_d;
        end
    end

    assign RGBStr_o = rgb_str_q;

endmodule

// File: tb/tb_pxs_pattern_gen.sv
// Self-checking bench for pxs_pattern_gen: CW=1 and CW=4 instances share one stimulus stream.
module tb_pxs_pattern_gen;
    import pxs_pkg::*;

    localparam int  BAR = 8;
    localparam bit  VSA = 1'b0;
`ifdef PXS_PATTERN_SCROLL_EN
    localparam int  SCROLL = 1;
`else
    localparam int  SCROLL = 0;
`endif

    logic px_clk = 1'b0;
    logic rst_n;
    always #5 px_clk = ~px_clk;

    pxs_pattern_gen_if #(.CW(1)) bus1 ();
    pxs_pattern_gen_if #(.CW(4)) bus4 ();
    assign bus4.vga_str = bus1.vga_str;
    assign bus4.mode    = bus1.mode;

    pxs_pattern_gen #(.CW(1), .BAR_LOG2(3), .VS_ACTIVE(1'b0), .SCROLL_STEP(1)) dut1 (
        .px_clk   (px_clk),
        .rst_n    (rst_n),
        .mode_i   (bus1.mode),
        .VGAStr_i (bus1.vga_str),
        .RGBStr_o (bus1.rgb_str)
    );

    pxs_pattern_gen #(.CW(4), .BAR_LOG2(3), .VS_ACTIVE(1'b0), .SCROLL_STEP(1)) dut4 (
        .px_clk   (px_clk),
        .rst_n    (rst_n),
        .mode_i   (bus4.mode),
        .VGAStr_i (bus4.vga_str),
        .RGBStr_o (bus4.rgb_str)
    );

    int vectors    = 0;
    int miscompares = 0;

    // Reference state: what the spec says the generator remembers between pixels
    bit m_prev;
    bit m_armed;
    int m_mode;
    int m_off;

    function automatic void model_reset();
        m_prev  = ~VSA;
        m_armed = 1'b0;
        m_mode  = 0;
        m_off   = 0;
    endfunction

    // Expected RGB word (R most significant) from pixel coordinates and frame state
    function automatic int exp_rgb(int cw, int mode, int x, int y, int off, bit act);
        int sx, all, idx, grey3;
        sx    = (x + off) % 1024;
        all   = (1 << cw) - 1;
        grey3 = 1 + (1 << cw) + (1 << (2 * cw));
        idx   = 0;
        if (!act) return 0;
        case (mode)
            0: idx = (sx / BAR) % 8;
            1: idx = (y / BAR) % 8;
            2: return (((sx / BAR) + (y / BAR)) % 2 == 1) ? all * grey3 : 0;
            default: return (sx / (1 << (10 - cw))) * grey3;
        endcase
        return ((idx / 4) % 2) * all * (1 << (2 * cw))
             + ((idx / 2) % 2) * all * (1 << cw)
             + (idx % 2) * all;
    endfunction

    task automatic check_outputs(string tag, logic [22:0] vin, int x, int y, bit act);
        logic [25:0] e1;
        logic [34:0] e4;
        e1 = {3'(exp_rgb(1, m_mode, x, y, m_off, act)), vin};
        e4 = {12'(exp_rgb(4, m_mode, x, y, m_off, act)), vin};
        vectors++;
        assert (bus1.rgb_str === e1) else begin
            miscompares++;
            $error("FAIL %s cw1: observed %h expected %h", tag, bus1.rgb_str, e1);
        end
        vectors++;
        assert (bus4.rgb_str === e4) else begin
            miscompares++;
            $error("FAIL %s cw4: observed %h expected %h", tag, bus4.rgb_str, e4);
        end
    endtask

    task automatic check_zero(string tag);
        vectors++;
        assert (bus1.rgb_str === 26'd0) else begin
            miscompares++;
            $error("FAIL %s cw1: observed %h expected 0", tag, bus1.rgb_str);
        end
        vectors++;
        assert (bus4.rgb_str === 35'd0) else begin
            miscompares++;
            $error("FAIL %s cw4: observed %h expected 0", tag, bus4.rgb_str);
        end
    endtask

    // One pixel: drive on falling edge, advance the model at the rising edge, check just after
    task automatic step(string tag, bit hs, bit vs, int x, int y, bit act, int mode_in);
        logic [22:0] vin;
        @(negedge px_clk);
        vin          = {hs, vs, 10'(x), 10'(y), act};
        bus1.vga_str = vin;
        bus1.mode    = 2'(mode_in);
        @(posedge px_clk);
        if (m_armed && vs == VSA && m_prev != VSA) begin
            m_mode = mode_in;
            m_off  = (m_off + SCROLL) % 1024;
        end
        m_prev  = vs;
        m_armed = 1'b1;
        #1;
        check_outputs(tag, vin, x % 1024, y % 1024, act);
    endtask

    initial begin
        rst_n        = 1'b0;
        bus1.vga_str = {1'b0, 1'b1, 10'd0, 10'd0, 1'b0};
        bus1.mode    = 2'd0;
        model_reset();
        #12;
        check_zero("reset");
        @(negedge px_clk);
        rst_n = 1'b1;

        // Vertical bars across the first 64 pixels of a line
        for (int x = 0; x < 64; x++) step("bars", 1'b0, 1'b1, x, 0, 1'b1, 0);

        // Mid-frame mode request must not take effect before the next VS
        for (int x = 0; x < 16; x++) step("mode_hold", 1'b0, 1'b1, x, 4, 1'b1, 2);
        step("check_white", 1'b0, 1'b0, 8, 0, 1'b1, 2);
        step("check_black", 1'b0, 1'b0, 8, 8, 1'b1, 2);

        // Blanking in every mode while timing fields pass through
        for (int m = 0; m < 4; m++) begin
            step("blank_vs", 1'b1, 1'b1, 0, 0, 1'b0, m);
            step("blank_fs", 1'b0, 1'b0, 100, 20, 1'b0, m);
            for (int i = 0; i < 8; i++)
                step("blank", 1'(i), 1'b1, $urandom_range(0, 1023), $urandom_range(0, 1023), 1'b0, m);
        end

        // Random timing, coordinates and mode requests
        for (int i = 0; i < 600; i++)
            step("random", 1'($urandom_range(0, 1)), ($urandom_range(0, 15) == 0) ? 1'b0 : 1'b1,
                 $urandom_range(0, 1023), $urandom_range(0, 1023), 1'($urandom_range(0, 3) != 0),
                 $urandom_range(0, 3));

        // Grey ramp end points
        step("ramp_vs", 1'b0, 1'b1, 0, 0, 1'b1, 3);
        step("ramp_3ff", 1'b0, 1'b0, 10'h3FF, 0, 1'b1, 3);
        step("ramp_040", 1'b0, 1'b0, 10'h040, 0, 1'b1, 3);

        // Asynchronous reset mid-line, released with VS already asserted
        step("pre_reset", 1'b0, 1'b0, 300, 7, 1'b1, 2);
        #2;
        rst_n = 1'b0;
        #1;
        check_zero("async_reset");
        model_reset();
        @(negedge px_clk);
        rst_n = 1'b1;
        for (int x = 0; x < 20; x++) step("post_reset", 1'b0, 1'b0, x, 9, 1'b1, 2);

        // Three frame starts, then the scrolled bar index at XC=5
        for (int f = 0; f < 3; f++) begin
            step("frame_idle", 1'b0, 1'b1, 5, 0, 1'b1, 0);
            step("frame_start", 1'b0, 1'b0, 5, 0, 1'b1, 0);
        end
        step("scroll_x5", 1'b0, 1'b1, 5, 0, 1'b1, 0);

        // 1024 frames bring the scroll offset back around
        for (int f = 0; f < 1024; f++) begin
            step("wrap_idle", 1'b0, 1'b1, 5, 0, 1'b1, 0);
            step("wrap_start", 1'b0, 1'b0, 5, 0, 1'b1, 0);
        end
        step("wrap_x5", 1'b0, 1'b1, 5, 0, 1'b1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
